// File: rtl/card_stream_tx.sv
// card_stream_tx: buffers up to DEPTH 4-bit card addresses and plays them to the card decoder,
// one card per card_ack handshake. Define CARD_TX_LOOP_EN for continuous display scanning.
module card_stream_tx #(
  parameter int         DEPTH       = 8,
  parameter int         ACK_TIMEOUT = 15,
  parameter logic [3:0] IDLE_CODE   = 4'hF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   mode,
  input  logic                         load_en,
  input  logic [3:0]                   load_card,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         card_ack,
  output logic [3:0]                   card_stream,
  output logic                         busy,
  output logic                         stream_done,
  output logic                         timeout_err,
  output logic [$clog2(DEPTH+1)-1:0]   hand_count,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    GAP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   timerNext;
  logic [3:0]      cardStream_q, cardStream_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeoutErr_q, timeoutErr_d;
  logic [2:0]      mode_q;
  logic            modeChange;
  logic            loadAccept;
  logic [3:0]      cardBuf_q [DEPTH];

  assign modeChange = (mode != mode_q) && (state_q != IDLE);
  assign timerNext  = timer_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    timeoutErr_d = timeoutErr_q;
    loadAccept   = 1'b0;

    if (clear) begin
      state_d      = IDLE;
      count_d      = '0;
      idx_d        = '0;
      timeoutErr_d = 1'b0;
    end else if (modeChange) begin
      state_d = IDLE;
`ifdef CARD_TX_LOOP_EN
    end else if (start && (state_q == SEND || state_q == WAIT_ACK || state_q == GAP)) begin
      // A start while scanning is the stop request; finish through DONE for the pulse.
      state_d = DONE;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            timeoutErr_d = 1'b0;
            idx_d        = '0;
            state_d      = (count_q == '0) ? DONE : SEND;
          end else if (load_en && !full) begin
            loadAccept = 1'b1;
            count_d    = count_q + 1'b1;
          end
        end
        SEND: begin
          timer_d = '0;
          state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          // timer counts cycles already spent showing this card; an ack on the final cycle wins.
          timer_d = timerNext;
          if (card_ack) begin
            if (idx_q == count_q - 1'b1) begin
`ifdef CARD_TX_LOOP_EN
              idx_d   = '0;
              state_d = GAP;
`else
              state_d = DONE;
`endif
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = GAP;
            end
          end else if (timerNext == TW'(ACK_TIMEOUT)) begin
            timeoutErr_d = 1'b1;
            state_d      = IDLE;
          end
        end
        GAP:     state_d = SEND;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    cardStream_d = IDLE_CODE;
    if (state_d == WAIT_ACK) cardStream_d = cardBuf_q[idx_q[IW-1:0]];
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      cardStream_q <= IDLE_CODE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      cardStream_q <= cardStream_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  always_ff @(posedge clk) begin
    if (loadAccept && !reset) cardBuf_q[count_q[IW-1:0]] <= load_card;
  end

  assign card_stream = cardStream_q;
  assign busy        = busy_q;
  assign stream_done = done_q;
  assign timeout_err = timeoutErr_q;
  assign hand_count  = count_q;
  assign full        = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_card_stream_tx.sv
// Self-checking bench for card_stream_tx: directed scenarios plus randomized load/stream rounds
// checked against a queue model of the hand and the handshake timing rules.
module tb_card_stream_tx;

  localparam int         DEPTH       = 8;
  localparam int         ACK_TIMEOUT = 15;
  localparam logic [3:0] IDLE_CODE   = 4'hF;
  localparam int         CW          = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic          load_en;
  logic [3:0]    load_card;
  logic          clear;
  logic          start;
  logic          card_ack;
  logic [3:0]    card_stream;
  logic          busy;
  logic          stream_done;
  logic          timeout_err;
  logic [CW-1:0] hand_count;
  logic          full;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [3:0] modelCards[$];

  card_stream_tx #(
    .DEPTH(DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .IDLE_CODE(IDLE_CODE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .load_en(load_en),
    .load_card(load_card),
    .clear(clear),
    .start(start),
    .card_ack(card_ack),
    .card_stream(card_stream),
    .busy(busy),
    .stream_done(stream_done),
    .timeout_err(timeout_err),
    .hand_count(hand_count),
    .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs (sampled at the next rising edge) and move to the following falling edge.
  task automatic applyStimulus(input logic l, input logic [3:0] c, input logic s, input logic a);
    load_en   = l;
    load_card = c;
    start     = s;
    card_ack  = a;
    @(negedge clk);
    load_en  = 1'b0;
    start    = 1'b0;
    card_ack = 1'b0;
  endtask

  task automatic loadCard(input logic [3:0] c);
    applyStimulus(1'b1, c, 1'b0, 1'b0);
    if (modelCards.size() < DEPTH) modelCards.push_back(c);
  endtask

  task automatic clearHand();
    clear = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    clear = 1'b0;
    modelCards.delete();
  endtask

  task automatic checkIdle(input string tag, input logic expTerr);
    checkOutput({tag, " stream"}, card_stream, IDLE_CODE);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " done"}, stream_done, 1'b0);
    checkOutput({tag, " timeout_err"}, timeout_err, expTerr);
    checkOutput({tag, " count"}, hand_count, modelCards.size());
    checkOutput({tag, " full"}, full, modelCards.size() == DEPTH);
  endtask

  // Plays the whole model hand; ack delay fixed (>=0) or random within the timeout window.
  // With noise set, loads and stray acks are thrown in where they must be ignored.
  task automatic playStream(input string tag, input int fixedDelay, input bit noise);
    int n;
    int d;
    n = modelCards.size();
    applyStimulus(noise ? 1'($urandom) : 1'b0, 4'($urandom), 1'b1, 1'b0);
    if (n == 0) begin
      checkOutput({tag, " empty done"}, stream_done, 1'b1);
      checkOutput({tag, " empty stream"}, card_stream, IDLE_CODE);
      checkOutput({tag, " empty terr"}, timeout_err, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      checkIdle({tag, " empty after"}, 1'b0);
      return;
    end
    checkOutput({tag, " send busy"}, busy, 1'b1);
    checkOutput({tag, " send stream"}, card_stream, IDLE_CODE);
    checkOutput({tag, " send terr"}, timeout_err, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(ACK_TIMEOUT - 1, 0));
      applyStimulus(noise ? 1'($urandom) : 1'b0, 4'($urandom), 1'b0, noise ? 1'($urandom) : 1'b0);
      checkOutput($sformatf("%s card%0d", tag, i), card_stream, modelCards[i]);
      for (int j = 0; j < d; j++) begin
        applyStimulus(noise ? 1'($urandom) : 1'b0, 4'($urandom), 1'b0, 1'b0);
      end
      checkOutput($sformatf("%s hold%0d", tag, i), card_stream, modelCards[i]);
      checkOutput($sformatf("%s hold busy%0d", tag, i), busy, 1'b1);
      applyStimulus(noise ? 1'($urandom) : 1'b0, 4'($urandom), 1'b0, 1'b1);
`ifndef CARD_TX_LOOP_EN
      if (i == n - 1) begin
        checkOutput({tag, " done pulse"}, stream_done, 1'b1);
        checkOutput({tag, " done busy"}, busy, 1'b1);
        checkOutput({tag, " done stream"}, card_stream, IDLE_CODE);
        continue;
      end
`endif
      checkOutput($sformatf("%s gap%0d", tag, i), card_stream, IDLE_CODE);
      checkOutput($sformatf("%s gap done%0d", tag, i), stream_done, 1'b0);
      applyStimulus(noise ? 1'($urandom) : 1'b0, 4'($urandom), 1'b0, noise ? 1'($urandom) : 1'b0);
      checkOutput($sformatf("%s resend%0d", tag, i), card_stream, IDLE_CODE);
    end
`ifdef CARD_TX_LOOP_EN
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput({tag, " wrap card0"}, card_stream, modelCards[0]);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput({tag, " stop done"}, stream_done, 1'b1);
    checkOutput({tag, " stop stream"}, card_stream, IDLE_CODE);
`endif
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkIdle({tag, " end"}, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1; mode = 3'd0; load_en = 1'b0; load_card = 4'h0;
    clear = 1'b0; start = 1'b0; card_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("reset", 1'b0);

    // Basic hand 3,7,2 with the ack two cycles into each card.
    loadCard(4'h3); loadCard(4'h7); loadCard(4'h2);
    checkOutput("load3 count", hand_count, 3);
    playStream("basic", 2, 1'b0);
    playStream("replay", 0, 1'b0);

    // Overfill: ninth card must be dropped.
    clearHand();
    checkIdle("clear", 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      loadCard(4'(i + 4));
      if (i == DEPTH - 1) checkOutput("full after 8th", full, 1'b1);
    end
    checkOutput("full count", hand_count, DEPTH);
    checkOutput("full flag", full, 1'b1);
    playStream("full", ACK_TIMEOUT - 1, 1'b0);

    // Empty start.
    clearHand();
    playStream("empty", 0, 1'b0);

    // Timeout on a withheld ack.
    loadCard(4'h5); loadCard(4'h5);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < ACK_TIMEOUT; k++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("to last card", card_stream, 4'h5);
    checkOutput("to not yet", timeout_err, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkIdle("timeout", 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("timeout sticky", timeout_err, 1'b1);
    playStream("after timeout", 1, 1'b0);

    // Mode change mid-stream aborts without a done pulse; buffer is kept.
    clearHand();
    loadCard(4'h1); loadCard(4'h4); loadCard(4'h6);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("mode card0", card_stream, 4'h1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    mode = 3'd3;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkIdle("mode abort", 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkIdle("mode settle", 1'b0);
    playStream("mode replay", 3, 1'b0);

    // Clear mid-stream.
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    clearHand();
    checkIdle("clear abort", 1'b0);

`ifndef CARD_TX_LOOP_EN
    // Start while busy is ignored in the one-shot build.
    loadCard(4'hA); loadCard(4'hB);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("busy start card", card_stream, 4'hA);
    checkOutput("busy start busy", busy, 1'b1);
    checkOutput("busy start done", stream_done, 1'b0);
    clearHand();
`endif

    // Randomized rounds.
    for (int r = 0; r < 12; r++) begin
      clearHand();
      n = $urandom_range(DEPTH + 2, 0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          mode = 3'($urandom);
          applyStimulus(1'b0, 4'h0, 1'b0, 1'($urandom));
        end
        loadCard(4'($urandom));
      end
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      checkIdle($sformatf("rand%0d idle", r), 1'b0);
      playStream($sformatf("rand%0d", r), -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
